ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Pipeline control-staging block for the 5-stage RV32I core. It receives the per-instruction control bits produced by the decoder in ID and carries them through the ID/EX, EX/MEM and MEM/WB registers. It inserts a bubble on load-use hazards, squashes the wrong-path instruction on a taken branch, and freezes on memory wait. It also produces the EX-stage operand forwarding selects, so the datapath stages consume control only from this block.

## Interface
- No parameters; register index width is fixed at 5, RV32I.
- clk  in  1  core clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite  in  1 each  decoder control bits for the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices of the ID instruction.
- ex_taken  in  1  branch comparator result for the instruction in EX.
- mem_wait  in  1  data memory not ready; freezes the pipe.
- ex_valid, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  ID/EX register.
- ex_rd  out  5  ID/EX rd.
- mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM register.
- mem_rd  out  5  EX/MEM rd.
- wb_valid, wb_memtoreg, wb_regwrite  out  1 each  MEM/WB register.
- wb_rd  out  5  MEM/WB rd.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 from MEM, 01 from WB.
- stall_if  out  1  hold PC and IF/ID (load-use).
- flush_id  out  1  invalidate IF/ID (taken branch).

## Operation
- Stage registers hold valid plus the control bits listed above. ID/EX also holds internal ex_rs1 and ex_rs2 for forwarding.
- Qualified signals:
  - take = ex_valid & ex_branch & ex_taken.
  - hazard = ex_valid & ex_memread & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Each edge with clr=0 and mem_wait=0:
  - MEM/WB <= EX/MEM and EX/MEM <= ID/EX, both with valid carried.
  - If take or hazard, ID/EX <= bubble: all bits 0, including valid.
  - Otherwise ID/EX <= ID inputs, with ex_valid <= id_valid.
- Bubble and invalid stages: every control output is gated with its stage valid. An invalid stage drives regwrite, memwrite and memread = 0.
- mem_wait=1: every stage register holds its value.
- stall_if = hazard & ~take & ~mem_wait.
- flush_id = take & ~mem_wait.
- Priority: take over hazard. The ID instruction being on the wrong path takes precedence, so no stall is asserted.
- Forwarding (combinational):
  - fwd_a = 10 if mem_valid & mem_regwrite & mem_rd != 0 & mem_rd == ex_rs1.
  - Otherwise fwd_a = 01 if wb_valid & wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1.
  - Otherwise fwd_a = 00.
  - fwd_b is the same with ex_rs2. MEM beats WB.
- Register x0 never forwards and never causes a stall.

## Timing
- Reset: clr=1 at an edge clears all stage registers, rd and rs fields, and valid bits to 0. All outputs read 0 in the cycle after. clr overrides mem_wait, take and hazard.
- Latency:
  - ID inputs appear on ex_* 1 edge later, mem_* 2 edges later and wb_* 3 edges later, given no freeze and no bubble.
- Load-use:
  - stall_if is asserted in the same cycle hazard is detected. One bubble is inserted into EX.
  - The next cycle the load is in MEM and hazard is 0. The dependent instruction then enters EX and gets fwd=01 once the load reaches WB.
  - Net cost is exactly 1 bubble.
- Taken branch:
  - flush_id is asserted in the cycle take=1, and the ID instruction becomes a bubble.
  - The upstream fetch logic flushes IF/ID on the same edge.
  - The branch instruction itself proceeds to MEM unchanged.
- mem_wait is combinationally effective. Releasing it resumes on the next edge with no lost or duplicated instruction.
- Outputs fwd_*, stall_if and flush_id are combinational from registers and ID inputs. All other outputs are registered.

## Test plan
- Reset:
  - Stimulus: drive junk on all inputs with clr=1 for 2 cycles, then clr=0 and id_valid=0.
  - Required: all outputs 0. Three edges later, wb_valid is still 0.
- Straight flow:
  - Stimulus: an ADD with rd=5, regwrite=1, then an ADD with rs1=5.
  - Required: the second instruction sees fwd_a=10 in EX. A third instruction with rs2=5 sees fwd_b=01. wb_rd=5 and wb_regwrite=1 appear 3 edges after issue.
- Load-use:
  - Stimulus: LW with rd=7, memread=1, memtoreg=1, then ADD with rs2=7.
  - Required: stall_if=1 for exactly 1 cycle and ex_valid=0 for 1 cycle. Then the ADD in EX has fwd_b=01.
  - Variant: the same sequence with rd=0. Required: no stall and fwd=00.
- Taken branch:
  - Stimulus: BEQ in EX with ex_taken=1 while a store is in ID.
  - Required: flush_id=1; next edge ex_valid=0 and ex_memwrite=0; mem_branch path continues.
- Branch and hazard together:
  - Stimulus: take=1 and hazard=1 in the same cycle.
  - Required: flush_id=1, stall_if=0, one bubble.
- Memory wait:
  - Stimulus: hold mem_wait=1 for 3 cycles with the pipe full.
  - Required: all stage outputs are unchanged and stall_if/flush_id are 0.
  - After release, the sequence continues with no duplication. A clr during mem_wait zeroes everything.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control staging for the 5-stage RV32I pipe: ID/EX, EX/MEM, MEM/WB
// control registers, load-use bubble, branch squash, freeze and forwarding.
module ctrl_pipe (
    input  logic       clk,
    input  logic       clr,
    input  logic       id_valid,
    input  logic       id_alusrc,
    input  logic       id_branch,
    input  logic       id_memread,
    input  logic       id_memwrite,
    input  logic       id_memtoreg,
    input  logic       id_regwrite,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       ex_taken,
    input  logic       mem_wait,
    output logic       ex_valid,
    output logic       ex_alusrc,
    output logic       ex_branch,
    output logic       ex_memread,
    output logic       ex_memwrite,
    output logic       ex_memtoreg,
    output logic       ex_regwrite,
    output logic [4:0] ex_rd,
    output logic       mem_valid,
    output logic       mem_memread,
    output logic       mem_memwrite,
    output logic       mem_memtoreg,
    output logic       mem_regwrite,
    output logic [4:0] mem_rd,
    output logic       wb_valid,
    output logic       wb_memtoreg,
    output logic       wb_regwrite,
    output logic [4:0] wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall_if,
    output logic       flush_id
);

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } mem_wb_t;

    id_ex_t  ex_q, ex_d;
    ex_mem_t mem_q;
    mem_wb_t wb_q;

    logic take, hazard;
    logic mem_hit, wb_hit;

    assign take   = ex_q.valid & ex_q.branch & ex_taken;
    assign hazard = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid
                  & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    // An invalid ID slot is loaded exactly like a bubble.
    always_comb begin
        ex_d = '0;
        if (id_valid && !take && !hazard) begin
            ex_d.valid    = 1'b1;
            ex_d.alusrc   = id_alusrc;
            ex_d.branch   = id_branch;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.memtoreg = id_memtoreg;
            ex_d.regwrite = id_regwrite;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait) begin
            ex_q           <= ex_d;
            mem_q.valid    <= ex_q.valid;
            mem_q.memread  <= ex_q.memread;
            mem_q.memwrite <= ex_q.memwrite;
            mem_q.memtoreg <= ex_q.memtoreg;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.rd       <= ex_q.rd;
            wb_q.valid     <= mem_q.valid;
            wb_q.memtoreg  <= mem_q.memtoreg;
            wb_q.regwrite  <= mem_q.regwrite;
            wb_q.rd        <= mem_q.rd;
        end
    end

    assign mem_hit = mem_q.valid & mem_q.regwrite & (mem_q.rd != 5'd0);
    assign wb_hit  = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_hit && mem_q.rd == ex_q.rs1)    fwd_a = 2'b10;
        else if (wb_hit && wb_q.rd == ex_q.rs1) fwd_a = 2'b01;
        if (mem_hit && mem_q.rd == ex_q.rs2)    fwd_b = 2'b10;
        else if (wb_hit && wb_q.rd == ex_q.rs2) fwd_b = 2'b01;
    end

    // A wrong-path ID instruction never stalls; the flush wins.
    assign stall_if = hazard & ~take & ~mem_wait;
    assign flush_id = take & ~mem_wait;

    assign ex_valid     = ex_q.valid;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_branch    = ex_q.branch;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_rd        = ex_q.rd;
    assign mem_valid    = mem_q.valid;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_rd       = mem_q.rd;
    assign wb_valid     = wb_q.valid;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard/branch/freeze scenarios plus a
// randomized run against a stage-list reference model.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       clr, id_valid, id_alusrc, id_branch, id_memread;
    logic       id_memwrite, id_memtoreg, id_regwrite;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_taken, mem_wait;
    logic       ex_valid, ex_alusrc, ex_branch, ex_memread, ex_memwrite;
    logic       ex_memtoreg, ex_regwrite;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_memtoreg, wb_regwrite;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, flush_id;

    int n_cmp = 0;
    int n_bad = 0;

    ctrl_pipe dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_alusrc(id_alusrc),
        .id_branch(id_branch), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_taken(ex_taken), .mem_wait(mem_wait),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if),
        .flush_id(flush_id)
    );

    always #5 clk = ~clk;

    logic [11:0] obs_ex;
    logic [9:0]  obs_mem;
    logic [7:0]  obs_wb;
    logic [5:0]  obs_ctl;
    assign obs_ex  = {ex_valid, ex_alusrc, ex_branch, ex_memread, ex_memwrite,
                      ex_memtoreg, ex_regwrite, ex_rd};
    assign obs_mem = {mem_valid, mem_memread, mem_memwrite, mem_memtoreg,
                      mem_regwrite, mem_rd};
    assign obs_wb  = {wb_valid, wb_memtoreg, wb_regwrite, wb_rd};
    assign obs_ctl = {stall_if, flush_id, fwd_a, fwd_b};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, a, b, mr, mw, mt, rw,
                          input logic [4:0] r1, r2, rd);
        id_valid = v; id_alusrc = a; id_branch = b; id_memread = mr;
        id_memwrite = mw; id_memtoreg = mt; id_regwrite = rw;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic idle;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 0; ex_taken = 0; mem_wait = 0;
        #1;
    endtask

    task automatic drain;
        idle;
        repeat (4) tick;
    endtask

    task automatic test_reset;
        set_id(1, 1, 1, 1, 1, 1, 1, 5'($urandom), 5'($urandom), 5'($urandom));
        clr = 1; ex_taken = 1; mem_wait = 1;
        repeat (2) tick;
        clr = 0; id_valid = 0;
        #1;
        n_cmp++;
        if ({obs_ex, obs_mem, obs_wb, obs_ctl} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0",
                     {obs_ex, obs_mem, obs_wb, obs_ctl});
        end
        mem_wait = 0;
        repeat (3) tick;
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wb_valid got %b want 0", wb_valid);
        end
    endtask

    task automatic test_straight;
        drain;
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 2, 5);
        tick;
        n_cmp++;
        if (obs_ex !== {7'b1000001, 5'd5}) begin
            n_bad++;
            $display("FAIL straight_ex got %h want %h", obs_ex, {7'b1000001, 5'd5});
        end
        set_id(1, 0, 0, 0, 0, 0, 1, 5, 3, 6);
        tick;
        n_cmp++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            n_bad++;
            $display("FAIL straight_fwd_mem got %b want 1000", {fwd_a, fwd_b});
        end
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 5, 8);
        tick;
        n_cmp++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            n_bad++;
            $display("FAIL straight_fwd_wb got %b want 0001", {fwd_a, fwd_b});
        end
        n_cmp++;
        if (obs_wb !== {3'b101, 5'd5}) begin
            n_bad++;
            $display("FAIL straight_wb got %h want %h", obs_wb, {3'b101, 5'd5});
        end
    endtask

    task automatic test_load_use;
        int stalls;
        drain;
        stalls = 0;
        set_id(1, 1, 0, 1, 0, 1, 1, 1, 0, 7);
        tick;
        set_id(1, 0, 0, 0, 0, 0, 1, 2, 7, 9);
        #1;
        stalls += int'(stall_if);
        n_cmp++;
        if ({stall_if, flush_id} !== 2'b10) begin
            n_bad++;
            $display("FAIL loaduse_stall got %b want 10", {stall_if, flush_id});
        end
        tick;
        stalls += int'(stall_if);
        n_cmp++;
        if ({ex_valid, stall_if} !== 2'b00) begin
            n_bad++;
            $display("FAIL loaduse_bubble got %b want 00", {ex_valid, stall_if});
        end
        tick;
        n_cmp++;
        if ({ex_valid, ex_rd, fwd_a, fwd_b} !== {1'b1, 5'd9, 4'b0001}) begin
            n_bad++;
            $display("FAIL loaduse_fwd got %h want %h",
                     {ex_valid, ex_rd, fwd_a, fwd_b}, {1'b1, 5'd9, 4'b0001});
        end
        n_cmp++;
        if (stalls !== 1) begin
            n_bad++;
            $display("FAIL loaduse_stall_count got %0d want 1", stalls);
        end
    endtask

    task automatic test_load_x0;
        drain;
        set_id(1, 1, 0, 1, 0, 1, 1, 1, 0, 0);
        tick;
        set_id(1, 0, 0, 0, 0, 0, 1, 2, 0, 9);
        #1;
        n_cmp++;
        if (stall_if !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_stall got %b want 0", stall_if);
        end
        tick;
        n_cmp++;
        if ({ex_valid, fwd_a, fwd_b} !== 5'b10000) begin
            n_bad++;
            $display("FAIL x0_fwd got %b want 10000", {ex_valid, fwd_a, fwd_b});
        end
    endtask

    task automatic test_branch;
        drain;
        set_id(1, 0, 1, 0, 0, 0, 0, 1, 2, 0);
        tick;
        set_id(1, 1, 0, 0, 1, 0, 0, 3, 4, 0);
        ex_taken = 1;
        #1;
        n_cmp++;
        if ({stall_if, flush_id} !== 2'b01) begin
            n_bad++;
            $display("FAIL branch_flush got %b want 01", {stall_if, flush_id});
        end
        tick;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({ex_valid, ex_memwrite, mem_valid, flush_id} !== 4'b0010) begin
            n_bad++;
            $display("FAIL branch_squash got %b want 0010",
                     {ex_valid, ex_memwrite, mem_valid, flush_id});
        end
        ex_taken = 0;
    endtask

    task automatic test_branch_hazard;
        drain;
        set_id(1, 0, 1, 1, 0, 1, 1, 1, 2, 10);
        tick;
        set_id(1, 0, 0, 0, 0, 0, 1, 10, 1, 11);
        ex_taken = 1;
        #1;
        n_cmp++;
        if ({stall_if, flush_id} !== 2'b01) begin
            n_bad++;
            $display("FAIL brhaz_ctl got %b want 01", {stall_if, flush_id});
        end
        tick;
        idle;
        n_cmp++;
        if ({ex_valid, mem_valid, mem_rd} !== {2'b01, 5'd10}) begin
            n_bad++;
            $display("FAIL brhaz_bubble got %h want %h",
                     {ex_valid, mem_valid, mem_rd}, {2'b01, 5'd10});
        end
    endtask

    task automatic test_mem_wait;
        drain;
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 1, 11);
        tick;
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 1, 12);
        tick;
        set_id(1, 1, 0, 1, 0, 1, 1, 1, 0, 13);
        tick;
        set_id(1, 0, 0, 0, 0, 0, 1, 13, 2, 14);
        mem_wait = 1;
        #1;
        n_cmp++;
        if ({stall_if, flush_id} !== 2'b00) begin
            n_bad++;
            $display("FAIL wait_ctl got %b want 00", {stall_if, flush_id});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if ({obs_ex, obs_mem, obs_wb, stall_if} !==
                {7'b1101011, 5'd13, 5'b10001, 5'd12, 3'b101, 5'd11, 1'b0}) begin
                n_bad++;
                $display("FAIL wait_hold cycle %0d got %h", i,
                         {obs_ex, obs_mem, obs_wb, stall_if});
            end
        end
        mem_wait = 0;
        #1;
        n_cmp++;
        if (stall_if !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_release_stall got %b want 1", stall_if);
        end
        tick;
        n_cmp++;
        if ({ex_valid, mem_valid, mem_rd, wb_valid, wb_rd} !==
            {2'b01, 5'd13, 1'b1, 5'd12}) begin
            n_bad++;
            $display("FAIL wait_resume1 got %h",
                     {ex_valid, mem_valid, mem_rd, wb_valid, wb_rd});
        end
        tick;
        n_cmp++;
        if ({ex_valid, ex_rd, mem_valid, wb_valid, wb_rd, fwd_a} !==
            {1'b1, 5'd14, 2'b01, 5'd13, 2'b01}) begin
            n_bad++;
            $display("FAIL wait_resume2 got %h",
                     {ex_valid, ex_rd, mem_valid, wb_valid, wb_rd, fwd_a});
        end
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 1, 15);
        tick;
        mem_wait = 1; clr = 1;
        tick;
        idle;
        n_cmp++;
        if ({obs_ex, obs_mem, obs_wb, obs_ctl} !== 36'd0) begin
            n_bad++;
            $display("FAIL wait_clr got %h want 0",
                     {obs_ex, obs_mem, obs_wb, obs_ctl});
        end
    endtask

    typedef struct packed {
        logic v, a, b, mr, mw, mt, rw;
        logic [4:0] rs1, rs2, rd;
    } ins_t;

    ins_t pipe [3];

    function automatic logic [1:0] src_of(input logic [4:0] rs);
        for (int s = 1; s <= 2; s++)
            if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == rs)
                return (s == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic test_random;
        logic take, haz;
        logic [5:0] e_ctl;
        ins_t nx;
        drain;
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        for (int c = 0; c < 500; c++) begin
            clr = ($urandom_range(0, 40) == 0);
            mem_wait = ($urandom_range(0, 4) == 0);
            ex_taken = 1'($urandom);
            set_id($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)));
            #1;
            take = pipe[0].v && pipe[0].b && ex_taken;
            haz = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && id_valid &&
                  (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
            e_ctl = {haz && !take && !mem_wait, take && !mem_wait,
                     src_of(pipe[0].rs1), src_of(pipe[0].rs2)};
            n_cmp++;
            if (obs_ctl !== e_ctl) begin
                n_bad++;
                $display("FAIL rand_ctl cycle %0d got %b want %b", c, obs_ctl, e_ctl);
            end
            nx = '{v: id_valid, a: id_alusrc, b: id_branch, mr: id_memread,
                   mw: id_memwrite, mt: id_memtoreg, rw: id_regwrite,
                   rs1: id_rs1, rs2: id_rs2, rd: id_rd};
            if (!id_valid || take || haz) nx = '0;
            if (clr) begin
                for (int s = 0; s < 3; s++) pipe[s] = '0;
            end else if (!mem_wait) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nx;
            end
            tick;
            n_cmp++;
            if ({obs_ex, obs_mem, obs_wb} !==
                {pipe[0].v, pipe[0].a, pipe[0].b, pipe[0].mr, pipe[0].mw,
                 pipe[0].mt, pipe[0].rw, pipe[0].rd,
                 pipe[1].v, pipe[1].mr, pipe[1].mw, pipe[1].mt, pipe[1].rw,
                 pipe[1].rd, pipe[2].v, pipe[2].mt, pipe[2].rw, pipe[2].rd}) begin
                n_bad++;
                $display("FAIL rand_stages cycle %0d got %h %h %h", c,
                         obs_ex, obs_mem, obs_wb);
            end
        end
        idle;
    endtask

    initial begin
        test_reset;
        test_straight;
        test_load_use;
        test_load_x0;
        test_branch;
        test_branch_hazard;
        test_mem_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
